// File: rtl/regfile_fwd.sv
// Decode-stage register file: byte-enable writeback, per-byte multi-stage forwarding,
// and a pending-write scoreboard for multi-cycle producers, with per-port stall requests.
module regfile_fwd #(
    parameter int NRD  = 2,
    parameter int NFWD = 2,
    parameter int DW   = 32,
    parameter int NREG = 32,
    localparam int NB  = DW / 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    input  logic [NB-1:0]     we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NFWD*NB-1:0] fwd_we,
    input  logic [NFWD*AW-1:0] fwd_addr,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]   fwd_rdy,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_set_addr,
    input  logic              sb_clr,
    input  logic [AW-1:0]     sb_clr_addr,
    input  logic              flush,
    output logic [NRD-1:0]    hazard,
    output logic [NFWD-1:0]   hazard_stage,
    output logic              hazard_sb,
    output logic [AW:0]       sb_count
);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] pend;
    logic            set_new;
    logic            clr_old;

    // Register array; address 0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (waddr != '0) begin
            for (int b = 0; b < NB; b++)
                if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // A same-register set and clear leaves the bit pending, so the clear is dropped.
    always_comb begin
        set_new = sb_set && (sb_set_addr != '0) && !pend[sb_set_addr];
        clr_old = sb_clr && pend[sb_clr_addr] &&
                  !(sb_set && (sb_set_addr == sb_clr_addr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            sb_count <= '0;
        end else if (flush) begin
            pend     <= '0;
            sb_count <= '0;
        end else begin
            if (clr_old) pend[sb_clr_addr] <= 1'b0;
            if (set_new) pend[sb_set_addr] <= 1'b1;
            sb_count <= sb_count + (AW+1)'(set_new) - (AW+1)'(clr_old);
        end
    end

    // Per-lane resolution: array, then WB, then stages oldest to youngest so the youngest wins.
    always_comb begin : resolve
        logic [AW-1:0] a;
        logic [7:0]    lane;
        logic          wb_hit;
        rdata        = '0;
        hazard       = '0;
        hazard_stage = '0;
        hazard_sb    = 1'b0;
        a            = '0;
        lane         = '0;
        wb_hit       = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            a = raddr[p*AW +: AW];
            if (re[p] && (a != '0)) begin
                for (int b = 0; b < NB; b++) begin
                    lane = mem[a][b*8 +: 8];
                    if (we[b] && (waddr == a)) lane = wdata[b*8 +: 8];
                    for (int s = NFWD - 1; s >= 0; s--)
                        if (fwd_we[s*NB + b] && (fwd_addr[s*AW +: AW] == a))
                            lane = fwd_data[s*DW + b*8 +: 8];
                    rdata[p*DW + b*8 +: 8] = lane;
                end
                for (int s = 0; s < NFWD; s++) begin
                    if ((fwd_addr[s*AW +: AW] == a) && (|fwd_we[s*NB +: NB]) && !fwd_rdy[s]) begin
                        hazard[p]       = 1'b1;
                        hazard_stage[s] = 1'b1;
                    end
                end
                wb_hit = sb_clr && (sb_clr_addr == a) && (waddr == a) && (|we);
                if (pend[a] && !wb_hit) begin
                    hazard[p] = 1'b1;
                    hazard_sb = 1'b1;
                end
            end
        end
    end

endmodule
